// File: rtl/imem_boot.sv
// Boot-loadable instruction memory: a byte-stream loader assembles little-endian
// words into a block RAM, and a registered fetch port serves them with fault codes.
module imem_boot #(
    parameter int          DEPTH     = 512,
    parameter int          ADDR_W    = $clog2(DEPTH),
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              load_restart,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic [1:0]        fetch_fault,
    output logic              boot_done,
    output logic [ADDR_W:0]   load_words
);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] WPTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORDS_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   WORDS_LAST = (ADDR_W + 1)'(DEPTH - 1);

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;
    localparam logic [1:0] FAULT_BOOT  = 2'b11;

    state_e              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         asm_q, asm_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]     load_words_q, load_words_d;

    logic                fetch_valid_q, fetch_valid_d;
    logic [1:0]          fetch_fault_q, fetch_fault_d;
    logic                use_ram_q, use_ram_d;
    logic [31:0]         rd_data_q;

    logic                xfer_s;
    logic                wr_en_s;
    logic [31:0]         wr_word_s;
    logic [29:0]         pc_word_s;
    logic [29:0]         words_ext_s;
    logic [ADDR_W-1:0]   rd_idx_s;

    logic [31:0]         mem [0:DEPTH-1];

    // Merge the incoming byte into its lane; lanes above it are zero-filled.
    function automatic logic [31:0] assemble_word(
        input logic [23:0] lanes,
        input logic [1:0]  cnt,
        input logic [7:0]  data
    );
        logic [31:0] word;
        case (cnt)
            2'd0:    word = {24'h00_0000, data};
            2'd1:    word = {16'h0000, data, lanes[7:0]};
            2'd2:    word = {8'h00, data, lanes[15:0]};
            2'd3:    word = {data, lanes[23:0]};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    assign xfer_s      = ld_valid && (state_q == S_LOAD);
    assign wr_en_s     = xfer_s && !load_restart && ((byte_cnt_q == 2'd3) || ld_last);
    assign wr_word_s   = assemble_word(asm_q, byte_cnt_q, ld_data);
    assign pc_word_s   = fetch_pc[31:2];
    assign words_ext_s = {{(30 - ADDR_W - 1){1'b0}}, load_words_q};
    assign rd_idx_s    = fetch_pc[ADDR_W+1:2];

    // Loader FSM: byte assembly, write pointer and LOAD/RUN sequencing.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        wptr_d       = wptr_q;
        load_words_d = load_words_q;
        if (load_restart) begin
            state_d      = S_LOAD;
            byte_cnt_d   = 2'd0;
            wptr_d       = {ADDR_W{1'b0}};
            load_words_d = {(ADDR_W + 1){1'b0}};
        end else if (wr_en_s) begin
            byte_cnt_d   = 2'd0;
            wptr_d       = wptr_q + WPTR_ONE;
            load_words_d = load_words_q + WORDS_ONE;
            if (ld_last || (load_words_q == WORDS_LAST)) begin
                state_d = S_RUN;
            end else begin
                state_d = S_LOAD;
            end
        end else if (xfer_s) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    asm_d[7:0]   = ld_data;
                2'd1:    asm_d[15:8]  = ld_data;
                2'd2:    asm_d[23:16] = ld_data;
                default: asm_d        = asm_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Fetch response: fault priority uses state and word count as registered now.
    always_comb begin
        fetch_valid_d = fetch_req;
        fetch_fault_d = FAULT_OK;
        use_ram_d     = 1'b0;
        if (fetch_req) begin
            if (state_q == S_LOAD) begin
                fetch_fault_d = FAULT_BOOT;
            end else if (fetch_pc[1:0] != 2'b00) begin
                fetch_fault_d = FAULT_ALIGN;
            end else if (pc_word_s >= words_ext_s) begin
                fetch_fault_d = FAULT_RANGE;
            end else begin
                use_ram_d = 1'b1;
            end
        end else begin
            fetch_fault_d = FAULT_OK;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_LOAD;
            byte_cnt_q    <= 2'd0;
            asm_q         <= 24'h00_0000;
            wptr_q        <= {ADDR_W{1'b0}};
            load_words_q  <= {(ADDR_W + 1){1'b0}};
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= FAULT_OK;
            use_ram_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            asm_q         <= asm_d;
            wptr_q        <= wptr_d;
            load_words_q  <= load_words_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            use_ram_q     <= use_ram_d;
        end
    end

    // Simple dual-port RAM, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wptr_q] <= wr_word_s;
        end
        if (fetch_req) begin
            rd_data_q <= mem[rd_idx_s];
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_instr = use_ram_q ? rd_data_q : NOP_INSTR;
    assign ld_ready    = (state_q == S_LOAD);
    assign boot_done   = (state_q == S_RUN);
    assign load_words  = load_words_q;

endmodule

// File: tb/tb_imem_boot.sv
// Bench for imem_boot: a word-level reference model checked every cycle, directed
// scenarios with literal expectations, and a randomized load/fetch phase.
module tb_imem_boot;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        ld_valid = 1'b0, ld_last = 1'b0, load_restart = 1'b0, fetch_req = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic [31:0] fetch_pc = 32'h0;
    logic        ld_ready, fetch_valid, boot_done;
    logic [31:0] fetch_instr;
    logic [1:0]  fetch_fault;
    logic [9:0]  load_words;

    logic        b_ld_valid = 1'b0, b_ld_last = 1'b0, b_load_restart = 1'b0, b_fetch_req = 1'b0;
    logic [7:0]  b_ld_data = 8'h00;
    logic [31:0] b_fetch_pc = 32'h0;
    logic        b_ld_ready, b_fetch_valid, b_boot_done;
    logic [31:0] b_fetch_instr;
    logic [1:0]  b_fetch_fault;
    logic [2:0]  b_load_words;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    imem_boot #(.DEPTH(512)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .load_restart(load_restart),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
        .boot_done(boot_done), .load_words(load_words)
    );

    imem_boot #(.DEPTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last), .ld_ready(b_ld_ready),
        .load_restart(b_load_restart),
        .fetch_req(b_fetch_req), .fetch_pc(b_fetch_pc),
        .fetch_valid(b_fetch_valid), .fetch_instr(b_fetch_instr), .fetch_fault(b_fetch_fault),
        .boot_done(b_boot_done), .load_words(b_load_words)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the DEPTH=512 instance: image as a word array plus a byte queue.
    logic [31:0] m_mem [512];
    logic [7:0]  m_bytes [$];
    int          m_words   = 0;
    bit          m_booted  = 1'b0;
    bit          m_exp_valid = 1'b0;
    logic [1:0]  m_exp_fault = 2'b00;
    logic [31:0] m_exp_instr = NOP;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_booted = 1'b0;
                m_words  = 0;
                m_bytes.delete();
                m_exp_valid = 1'b0;
                m_exp_fault = 2'b00;
                m_exp_instr = NOP;
            end else begin
                m_exp_valid = fetch_req;
                m_exp_fault = 2'b00;
                m_exp_instr = NOP;
                if (fetch_req) begin
                    if (!m_booted)                       m_exp_fault = 2'b11;
                    else if (fetch_pc % 4 != 0)          m_exp_fault = 2'b01;
                    else if ((fetch_pc / 4) >= m_words)  m_exp_fault = 2'b10;
                    else                                 m_exp_instr = m_mem[fetch_pc / 4];
                end
                if (load_restart) begin
                    m_booted = 1'b0;
                    m_words  = 0;
                    m_bytes.delete();
                end else if (ld_valid && !m_booted) begin
                    m_bytes.push_back(ld_data);
                    if (m_bytes.size() == 4 || ld_last) begin
                        logic [31:0] w;
                        w = 32'h0;
                        for (int i = 0; i < m_bytes.size(); i++) w = w + (32'(m_bytes[i]) << (8 * i));
                        m_mem[m_words] = w;
                        m_words++;
                        m_bytes.delete();
                        if (ld_last || m_words == 512) m_booted = 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_fetch_valid", 32'(fetch_valid), 32'(m_exp_valid));
            if (m_exp_valid) begin
                check("cyc_fetch_fault", 32'(fetch_fault), 32'(m_exp_fault));
                check("cyc_fetch_instr", fetch_instr, m_exp_instr);
            end
            check("cyc_boot_done", 32'(boot_done), 32'(m_booted));
            check("cyc_ld_ready", 32'(ld_ready), 32'(!m_booted));
            check("cyc_load_words", 32'(load_words), 32'(m_words));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic fetch1(input logic [31:0] pc);
        fetch_req = 1'b1; fetch_pc = pc;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic b_fetch1(input logic [31:0] pc);
        b_fetch_req = 1'b1; b_fetch_pc = pc;
        tick();
        b_fetch_req = 1'b0;
    endtask

    task automatic restart_a();
        load_restart = 1'b1;
        tick();
        load_restart = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(fetch_valid), 32'd0);
        check({tag, "_instr"}, fetch_instr, NOP);
        check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
        check({tag, "_boot"}, 32'(boot_done), 32'd0);
        check({tag, "_ready"}, 32'(ld_ready), 32'd1);
        check({tag, "_words"}, 32'(load_words), 32'd0);
    endtask

    logic [7:0] img1 [8];
    int r;

    initial begin
        img1[0] = 8'h13; img1[1] = 8'h00; img1[2] = 8'h00; img1[3] = 8'h00;
        img1[4] = 8'h93; img1[5] = 8'h07; img1[6] = 8'h40; img1[7] = 8'h06;

        #2;
        check_reset_outputs("rst0");
        #15 reset_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Two-word image.
        for (int i = 0; i < 8; i++) send_byte(img1[i], (i == 7));
        check("img1_boot", 32'(boot_done), 32'd1);
        check("img1_ready", 32'(ld_ready), 32'd0);
        check("img1_words", 32'(load_words), 32'd2);
        check("model_mem0", m_mem[0], 32'h0000_0013);
        check("model_mem1", m_mem[1], 32'h0640_0793);
        fetch1(32'h4);
        check("f4_valid", 32'(fetch_valid), 32'd1);
        check("f4_instr", fetch_instr, 32'h0640_0793);
        check("f4_fault", 32'(fetch_fault), 32'd0);
        fetch1(32'h8);
        check("f8_instr", fetch_instr, NOP);
        check("f8_fault", 32'(fetch_fault), 32'd2);
        fetch1(32'h6);
        check("f6_fault", 32'(fetch_fault), 32'd1);
        fetch1(32'h1000_0000);
        check("fhi_fault", 32'(fetch_fault), 32'd2);

        // Back-to-back fetches.
        fetch_req = 1'b1; fetch_pc = 32'h0;
        tick();
        check("b2b0_valid", 32'(fetch_valid), 32'd1);
        check("b2b0_instr", fetch_instr, 32'h0000_0013);
        fetch_pc = 32'h4;
        tick();
        fetch_req = 1'b0;
        check("b2b1_valid", 32'(fetch_valid), 32'd1);
        check("b2b1_instr", fetch_instr, 32'h0640_0793);
        tick();
        check("b2b_idle", 32'(fetch_valid), 32'd0);

        // Restart in RUN alongside a fetch: response uses pre-restart state.
        load_restart = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h0;
        tick();
        load_restart = 1'b0; fetch_req = 1'b0;
        check("rs_fault", 32'(fetch_fault), 32'd0);
        check("rs_instr", fetch_instr, 32'h0000_0013);
        check("rs_boot", 32'(boot_done), 32'd0);
        check("rs_words", 32'(load_words), 32'd0);
        check("rs_ready", 32'(ld_ready), 32'd1);
        fetch1(32'h0);
        check("rs_fetch_fault", 32'(fetch_fault), 32'd3);
        check("rs_fetch_instr", fetch_instr, NOP);

        // Five-byte image with a partial final word.
        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        fetch1(32'h0);
        check("ld_fetch_fault", 32'(fetch_fault), 32'd3);
        check("ld_fetch_instr", fetch_instr, NOP);
        send_byte(8'hAB, 1'b1);
        check("img2_boot", 32'(boot_done), 32'd1);
        check("img2_words", 32'(load_words), 32'd2);
        fetch1(32'h4);
        check("img2_mem1", fetch_instr, 32'h0000_00AB);
        check("img2_fault", 32'(fetch_fault), 32'd0);

        // DEPTH=4 instance fills without ld_last.
        for (int i = 0; i < 16; i++) begin
            b_ld_valid = 1'b1; b_ld_data = 8'(i + 1);
            tick();
        end
        b_ld_valid = 1'b0;
        check("b_boot", 32'(b_boot_done), 32'd1);
        check("b_words", 32'(b_load_words), 32'd4);
        check("b_ready", 32'(b_ld_ready), 32'd0);
        b_ld_valid = 1'b1; b_ld_data = 8'hEE;
        tick();
        b_ld_valid = 1'b0;
        check("b_17th_words", 32'(b_load_words), 32'd4);
        b_fetch1(32'hC);
        check("b_fc_instr", b_fetch_instr, 32'h100F_0E0D);
        check("b_fc_fault", 32'(b_fetch_fault), 32'd0);
        b_fetch1(32'h10);
        check("b_f10_fault", 32'(b_fetch_fault), 32'd2);
        check("b_f10_instr", b_fetch_instr, NOP);

        // Asynchronous reset in the middle of a word.
        restart_a();
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst1");
        tick();
        #2 reset_n = 1'b1;
        tick();
        send_byte(8'h44, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h11, 1'b1);
        check("rst1_words", 32'(load_words), 32'd1);
        fetch1(32'h0);
        check("rst1_word0", fetch_instr, 32'h1122_3344);

        // Randomized loads, restarts and fetches against the model.
        for (int c = 0; c < 3000; c++) begin
            ld_valid     = 1'($urandom_range(0, 1));
            ld_data      = 8'($urandom);
            ld_last      = ($urandom_range(0, 15) == 0);
            load_restart = ($urandom_range(0, 63) == 0);
            fetch_req    = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 7)       fetch_pc = 32'($urandom_range(0, 15)) << 2;
            else if (r == 7) fetch_pc = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
            else if (r == 8) fetch_pc = 32'h1000_0000 | (32'($urandom_range(0, 3)) << 2);
            else             fetch_pc = $urandom;
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0; load_restart = 1'b0; fetch_req = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
